alu_pipe_frontend: RTL and testbench
====================================

Name: alu_pipe_frontend

Overview:
- Handshaked, 2-stage pipelined front end around the existing combinational ALU32Bit.
- Accepts operation requests (op, a, b, tag) on a valid/ready interface and issues them to ALU32Bit.
- Derives cin from op; callers do not supply it.
- Captures result and status flags, and returns them in order on a valid/ready response interface to the issuing sequencer.

Parameters:
- TAG_W, 4, width of the opaque request tag carried through to the response.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; all other codes are illegal.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_tag  in  TAG_W  tag, returned unchanged.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  ALU result.
- rsp_cout  out  1  carry-out; ADD/SUB only, otherwise 0.
- rsp_zero  out  1  rsp_result == 0.
- rsp_ovf  out  1  signed overflow; ADD/SUB only, otherwise 0.
- rsp_err  out  1  illegal op code.
- rsp_tag  out  TAG_W  tag of the request.
- done_count  out  CNT_W  number of completed responses (rsp_valid && rsp_ready), wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, synchronous deassert by clk): s1_valid=0, s2_valid=0, req_ready=1, rsp_valid=0, all rsp_* data outputs 0, done_count=0.
- Stage S1 (operand register):
  - Loads op/a/b/tag when req_valid && req_ready.
  - ALU32Bit is driven combinationally from the S1 registers.
  - cin = 1 for op 110/111, else 0.
- Stage S2 (result register):
  - Loads result, cout, zero, ovf, err and tag when s1_valid && s2_adv.
  - s2_adv = !s2_valid || rsp_ready.
- Handshake:
  - req_ready = !s1_valid || s2_adv (combinational from rsp_ready; no skid).
  - rsp_valid = s2_valid.
  - An unaccepted response holds all rsp_* stable.
- Latency: request accepted at edge N yields rsp_valid high after edge N+1 (visible in cycle N+1 to N+2). Throughput is 1 per cycle with rsp_ready held high.
- Ordering: strictly in order; no reordering or dropping. Maximum 2 requests in flight.
- Simultaneous events:
  - When S2 drains and S1 advances in the same cycle, both occur and a new request is accepted.
  - When S1 empties with no new request, s1_valid clears.
- Flags:
  - ADD ovf = (a[31]==b[31]) && (r[31]!=a[31]).
  - SUB ovf = (a[31]!=b[31]) && (r[31]!=a[31]).
  - SLT result is 0 or 1; cout=0 and ovf=0 for SLT.
  - zero is computed on the final result, including SLT and illegal ops.
- Illegal op: result=0, cout=0, ovf=0, zero=1, err=1. The transaction still completes and is counted.
- done_count increments on each rsp_valid && rsp_ready and wraps from all-ones to 0.
- Reset mid-operation: in-flight requests are discarded with no response, and the counter clears.
- Request data is don't-care while req_valid=0; the S1 registers hold their value.

Decomposition:
- Shared package alu_pkg:
  - op enum (OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110, OP_SLT=3'b111).
  - Function is_legal_op(op).
  - Function op_cin(op).
- One sub-module: the existing ALU32Bit, instantiated unmodified as the datapath.
- Pipeline control and flag logic are written inline.

Test Plan:
- ADD a=FFFFFFFF, b=00000001, rsp_ready=1 -> result 00000000, cout=1, zero=1, ovf=0, response 2 cycles after accept.
- SUB a=20000000, b=10000000 -> result 10000000, cout=1, ovf=0. SUB a=80000000, b=00000001 -> result 7FFFFFFF, ovf=1.
- SLT a=00000001, b=00000010 -> result 00000001, zero=0. Back-to-back AND FFFFFFFF&0F0F0F0F -> 0F0F0F0F, then OR AAAAAAAA|55555555 -> FFFFFFFF; in-order tags 1 and 2.
- Backpressure: rsp_ready=0, drive 3 requests -> first 2 accepted, req_ready=0 on the third; rsp_* held stable. Release -> 3 responses in order, done_count=3.
- Illegal op 3'b011 -> result 0, err=1, zero=1, done_count increments.
- Assert rst with 2 requests in flight -> rsp_valid=0 and done_count=0 immediately (async). After release, req_ready=1 and no stale response appears.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op encoding and small helpers for the pipelined ALU front end.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (alu_op_e'(op))
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  // Subtract-style ops need +1 to complete the two's complement of B.
  function automatic logic op_cin(input logic [OP_W-1:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/ALU32Bit.sv
// Combinational 32-bit ALU: ctl[2] inverts B, ctl[1:0] selects AND/OR/SUM/SLT.
module ALU32Bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  input  logic [2:0]  i_ctl,
  output logic [31:0] o_result,
  output logic        o_cout,
  output logic        o_ovf
);

  logic [31:0] w_bb;
  logic [31:0] w_sum;

  assign w_bb = i_ctl[2] ? ~i_b : i_b;
  assign {o_cout, w_sum} = 33'(i_a) + 33'(w_bb) + 33'(i_cin);
  assign o_ovf = (i_a[31] == w_bb[31]) && (w_sum[31] != i_a[31]);

  // SLT uses the sign of A-B corrected by overflow.
  always_comb begin
    o_result = '0;
    case (i_ctl[1:0])
      2'b00:   o_result = i_a & w_bb;
      2'b01:   o_result = i_a | w_bb;
      2'b10:   o_result = w_sum;
      default: o_result = {31'b0, w_sum[31] ^ o_ovf};
    endcase
  end

endmodule

// File: rtl/alu_pipe_frontend.sv
// Two-stage valid/ready pipeline (operand reg, result reg) around ALU32Bit,
// returning results and flags in order with a completed-transaction counter.
module alu_pipe_frontend #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] done_count
);

  import alu_pkg::*;

  logic              r_s1_valid;
  logic [OP_W-1:0]   r_s1_op;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [TAG_W-1:0]  r_s1_tag;

  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_result;
  logic              r_s2_cout;
  logic              r_s2_zero;
  logic              r_s2_ovf;
  logic              r_s2_err;
  logic [TAG_W-1:0]  r_s2_tag;
  logic [CNT_W-1:0]  r_done_count;

  logic              w_s2_adv;
  logic              w_accept;
  logic              w_s1_move;
  logic              w_rsp_fire;
  logic              w_legal;
  logic              w_arith;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_cout;
  logic              w_alu_ovf;
  logic [DATA_W-1:0] w_result;
  logic              w_cout;
  logic              w_ovf;

  assign w_s2_adv   = !r_s2_valid || rsp_ready;
  assign req_ready  = !r_s1_valid || w_s2_adv;
  assign w_accept   = req_valid && req_ready;
  assign w_s1_move  = r_s1_valid && w_s2_adv;
  assign w_rsp_fire = r_s2_valid && rsp_ready;

  ALU32Bit u_alu (
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .i_cin    (op_cin(r_s1_op)),
    .i_ctl    (r_s1_op),
    .o_result (w_alu_result),
    .o_cout   (w_alu_cout),
    .o_ovf    (w_alu_ovf)
  );

  // Carry/overflow are only meaningful for ADD/SUB; illegal ops return zero.
  assign w_legal  = is_legal_op(r_s1_op);
  assign w_arith  = (r_s1_op == OP_ADD) || (r_s1_op == OP_SUB);
  assign w_result = w_legal ? w_alu_result : '0;
  assign w_cout   = w_arith && w_alu_cout;
  assign w_ovf    = w_arith && w_alu_ovf;

  // Stage 1: operand register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_tag   <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_op    <= req_op;
        r_s1_a     <= req_a;
        r_s1_b     <= req_b;
        r_s1_tag   <= req_tag;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: result register, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_cout   <= 1'b0;
      r_s2_zero   <= 1'b0;
      r_s2_ovf    <= 1'b0;
      r_s2_err    <= 1'b0;
      r_s2_tag    <= '0;
    end else begin
      if (w_s1_move) begin
        r_s2_valid  <= 1'b1;
        r_s2_result <= w_result;
        r_s2_cout   <= w_cout;
        r_s2_zero   <= (w_result == '0);
        r_s2_ovf    <= w_ovf;
        r_s2_err    <= !w_legal;
        r_s2_tag    <= r_s1_tag;
      end else if (rsp_ready) begin
        r_s2_valid  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_count <= '0;
    end else if (w_rsp_fire) begin
      r_done_count <= r_done_count + CNT_W'(1);
    end
  end

  assign rsp_valid  = r_s2_valid;
  assign rsp_result = r_s2_result;
  assign rsp_cout   = r_s2_cout;
  assign rsp_zero   = r_s2_zero;
  assign rsp_ovf    = r_s2_ovf;
  assign rsp_err    = r_s2_err;
  assign rsp_tag    = r_s2_tag;
  assign done_count = r_done_count;

endmodule

// File: tb/tb_alu_pipe_frontend.sv
// Directed bench for alu_pipe_frontend: latency, flags, back-to-back,
// backpressure, illegal op and mid-flight reset.
module tb_alu_pipe_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_cout;
  logic        rsp_zero;
  logic        rsp_ovf;
  logic        rsp_err;
  logic [3:0]  rsp_tag;
  logic [15:0] done_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_done = 0;

  alu_pipe_frontend #(.TAG_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
    .rsp_zero   (rsp_zero),
    .rsp_ovf    (rsp_ovf),
    .rsp_err    (rsp_err),
    .rsp_tag    (rsp_tag),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    req_valid = v;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
  endtask

  // flags packed as {cout, zero, ovf, err}
  task automatic check_rsp(input string name, input logic [31:0] res,
                           input logic [3:0] flags, input logic [3:0] tag);
    check({name, " valid"}, 64'(rsp_valid), 64'd1);
    check({name, " result"}, 64'(rsp_result), 64'(res));
    check({name, " flags"}, 64'({rsp_cout, rsp_zero, rsp_ovf, rsp_err}), 64'(flags));
    check({name, " tag"}, 64'(rsp_tag), 64'(tag));
  endtask

  task automatic single(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag,
                        input logic [31:0] res, input logic [3:0] flags);
    rsp_ready = 1'b1;
    drive(1'b1, op, a, b, tag);
    check({name, " req_ready"}, 64'(req_ready), 64'd1);
    step();
    drive(1'b0, 3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hF);
    check({name, " not yet valid"}, 64'(rsp_valid), 64'd0);
    step();
    check_rsp(name, res, flags, tag);
    step();
    exp_done++;
    check({name, " drained"}, 64'(rsp_valid), 64'd0);
    check({name, " done_count"}, 64'(done_count), 64'(exp_done));
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 4'h0);
    #1;
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset done_count", 64'(done_count), 64'd0);
    check("reset rsp data", 64'({rsp_result, rsp_cout, rsp_zero, rsp_ovf, rsp_err, rsp_tag}), 64'd0);
    repeat (2) step();
    rst = 1'b0;
    step();

    single("add wrap", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 4'h1, 32'h0000_0000, 4'b1100);
    single("add ovf", 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 4'h2, 32'h8000_0000, 4'b0010);
    single("sub pos", 3'b110, 32'h2000_0000, 32'h1000_0000, 4'h3, 32'h1000_0000, 4'b1000);
    single("sub ovf", 3'b110, 32'h8000_0000, 32'h0000_0001, 4'h4, 32'h7FFF_FFFF, 4'b1010);
    single("slt", 3'b111, 32'h0000_0001, 32'h0000_0010, 4'h5, 32'h0000_0001, 4'b0000);
    single("slt neg", 3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 4'h6, 32'h0000_0001, 4'b0000);
    single("illegal", 3'b011, 32'h1234_5678, 32'h1111_1111, 4'h7, 32'h0000_0000, 4'b0101);

    // Back-to-back AND then OR with throughput 1.
    rsp_ready = 1'b1;
    drive(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 4'h1);
    step();
    drive(1'b1, 3'b001, 32'hAAAA_AAAA, 32'h5555_5555, 4'h2);
    check("b2b second ready", 64'(req_ready), 64'd1);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 4'h0);
    check_rsp("b2b and", 32'h0F0F_0F0F, 4'b0000, 4'h1);
    step();
    check_rsp("b2b or", 32'hFFFF_FFFF, 4'b0000, 4'h2);
    step();
    exp_done += 2;
    check("b2b drained", 64'(rsp_valid), 64'd0);
    check("b2b done_count", 64'(done_count), 64'(exp_done));

    // Backpressure: two fill the pipe, third stalls until release.
    rsp_ready = 1'b0;
    drive(1'b1, 3'b010, 32'd1, 32'd2, 4'h3);
    check("bp r1 ready", 64'(req_ready), 64'd1);
    step();
    drive(1'b1, 3'b010, 32'd3, 32'd4, 4'h4);
    check("bp r2 ready", 64'(req_ready), 64'd1);
    step();
    drive(1'b1, 3'b010, 32'd5, 32'd6, 4'h5);
    check("bp r3 stalled", 64'(req_ready), 64'd0);
    check_rsp("bp hold a", 32'd3, 4'b0000, 4'h3);
    step();
    check("bp r3 still stalled", 64'(req_ready), 64'd0);
    check_rsp("bp hold b", 32'd3, 4'b0000, 4'h3);
    check("bp count held", 64'(done_count), 64'(exp_done));
    rsp_ready = 1'b1;
    #1;
    check("bp release ready", 64'(req_ready), 64'd1);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 4'h0);
    check_rsp("bp rsp2", 32'd7, 4'b0000, 4'h4);
    step();
    check_rsp("bp rsp3", 32'd11, 4'b0000, 4'h5);
    step();
    exp_done += 3;
    check("bp drained", 64'(rsp_valid), 64'd0);
    check("bp done_count", 64'(done_count), 64'(exp_done));

    // Reset with two requests in flight.
    rsp_ready = 1'b0;
    drive(1'b1, 3'b010, 32'd10, 32'd20, 4'h8);
    step();
    drive(1'b1, 3'b010, 32'd30, 32'd40, 4'h9);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 4'h0);
    check("rst pre valid", 64'(rsp_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst async valid", 64'(rsp_valid), 64'd0);
    check("rst async count", 64'(done_count), 64'd0);
    step();
    step();
    rst = 1'b0;
    exp_done = 0;
    rsp_ready = 1'b1;
    #1;
    check("rst release ready", 64'(req_ready), 64'd1);
    step();
    check("rst no stale a", 64'(rsp_valid), 64'd0);
    step();
    check("rst no stale b", 64'(rsp_valid), 64'd0);
    check("rst count zero", 64'(done_count), 64'd0);

    single("post rst add", 3'b010, 32'h0000_0100, 32'h0000_0023, 4'hA, 32'h0000_0123, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
